gcd_operand_stage: RTL and testbench

- Parametrised, registered successor to the GCD datapath's combinational operand-select mux.
- Holds the two GCD operands in registers and accepts a new operand pair through a valid/ready handshake.
- Each cycle, each operand register updates from a per-operand select: hold, feedback, or swap.
- Provides compare flags to the controller, counts iterations with a timeout, and returns the result through a valid/ready handshake.

---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_operand_stage_if.sv | 25 ++
 rtl/gcd_operand_reg.sv | 36 +++
 rtl/gcd_operand_stage.sv | 135 +++++++++++++
 tb/tb_gcd_operand_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared encodings for the GCD operand stage: per-operand update selects and FSM states.
package gcd_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_FB   = 2'b01;
  localparam logic [1:0] SEL_SWAP = 2'b10;
  localparam logic [1:0] SEL_RSV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gcd_operand_stage_if.sv
// Operand-in and result-out valid/ready channels of the GCD operand stage.
interface gcd_operand_stage_if #(
  parameter int WIDTH = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             timeout;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, timeout
  );

endinterface

// File: rtl/gcd_operand_reg.sv
// One GCD operand register: external load wins, otherwise hold / feedback / take-other when enabled.
module gcd_operand_reg
  import gcd_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_ext,
  input  logic [WIDTH-1:0] ext,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] fb,
  input  logic [WIDTH-1:0] other,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load_ext) begin
      q_reg <= ext;
    end else if (en) begin
      case (sel)
        SEL_FB:            q_reg <= fb;
        SEL_SWAP:          q_reg <= other;
        SEL_HOLD, SEL_RSV: q_reg <= q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/gcd_operand_stage.sv
// Registered GCD operand stage: accepts an operand pair, iterates under controller selects,
// and hands back the result with a MAX_ITER timeout guard.
module gcd_operand_stage
  import gcd_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int CNT_W       = 8,
  parameter int MAX_ITER    = 255,
  parameter bit AUTO_FINISH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcd_operand_stage_if.slave   bus,
  input  logic [1:0]           sel_a,
  input  logic [1:0]           sel_b,
  input  logic [WIDTH-1:0]     fb_a,
  input  logic [WIDTH-1:0]     fb_b,
  input  logic                 finish,
  output logic [WIDTH-1:0]     a_q,
  output logic [WIDTH-1:0]     b_q,
  output logic                 a_eq_b,
  output logic                 a_lt_b,
  output logic                 busy,
  output logic [CNT_W-1:0]     iter_cnt
);

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] iter_cnt_reg, iter_cnt_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             timeout_reg, timeout_next;

  logic             accept, zero_pair, auto_done, run_stop, step;
  logic [WIDTH-1:0] ops_q   [2];
  logic [WIDTH-1:0] ops_ext [2];
  logic [WIDTH-1:0] ops_fb  [2];
  logic [1:0]       ops_sel [2];

  assign ops_ext[0] = bus.in_a;
  assign ops_ext[1] = bus.in_b;
  assign ops_fb[0]  = fb_a;
  assign ops_fb[1]  = fb_b;
  assign ops_sel[0] = sel_a;
  assign ops_sel[1] = sel_b;

  // Each register sees the other's current value, so a double swap exchanges them in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      gcd_operand_reg #(.WIDTH(WIDTH)) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_ext (accept),
        .ext      (ops_ext[gi]),
        .sel      (ops_sel[gi]),
        .fb       (ops_fb[gi]),
        .other    (ops_q[1-gi]),
        .en       (step),
        .q        (ops_q[gi])
      );
    end
  endgenerate

  assign a_q    = ops_q[0];
  assign b_q    = ops_q[1];
  assign a_eq_b = (a_q == b_q);
  assign a_lt_b = (a_q < b_q);

  assign accept    = (state_reg == IDLE) && bus.in_valid;
  assign zero_pair = (bus.in_a == '0) || (bus.in_b == '0);
  assign auto_done = AUTO_FINISH && a_eq_b;
  assign run_stop  = finish || auto_done || (iter_cnt_reg == ITER_LIMIT);
  assign step      = (state_reg == RUN) && !run_stop;

  always_comb begin
    state_next    = state_reg;
    iter_cnt_next = iter_cnt_reg;
    out_data_next = out_data_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          iter_cnt_next = '0;
          timeout_next  = 1'b0;
          if (zero_pair) begin
            state_next    = DONE;
            out_data_next = bus.in_a | bus.in_b;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (run_stop) begin
          state_next    = DONE;
          out_data_next = a_q;
          // Only the iteration limit, not finish or equality, marks a forced result.
          timeout_next  = !finish && !auto_done;
        end else if (iter_cnt_reg != CNT_MAX) begin
          iter_cnt_next = iter_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      iter_cnt_reg <= '0;
      out_data_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      iter_cnt_reg <= iter_cnt_next;
      out_data_reg <= out_data_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = out_data_reg;
  assign bus.timeout   = timeout_reg;
  assign busy          = (state_reg == RUN);
  assign iter_cnt      = iter_cnt_reg;

endmodule

// File: tb/tb_gcd_operand_stage.sv
// Directed bench for gcd_operand_stage: subtractive-GCD vector table, swap/finish, backpressure,
// asynchronous reset, and a MAX_ITER timeout instance.
module tb_gcd_operand_stage;
  import gcd_pkg::*;

  localparam int W  = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_operand_stage_if #(.WIDTH(W)) bus ();
  gcd_operand_stage_if #(.WIDTH(W)) tbus ();

  logic [1:0]    sel_a, sel_b, t_sel_a, t_sel_b;
  logic [W-1:0]  fb_a, fb_b, t_fb_a, t_fb_b;
  logic          finish, t_finish;
  logic [W-1:0]  a_q, b_q, t_a_q, t_b_q;
  logic          a_eq_b, a_lt_b, busy, t_a_eq_b, t_a_lt_b, t_busy;
  logic [CW-1:0] iter_cnt, t_iter_cnt;

  gcd_operand_stage #(.WIDTH(W), .CNT_W(CW), .MAX_ITER(255), .AUTO_FINISH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sel_a(sel_a), .sel_b(sel_b), .fb_a(fb_a), .fb_b(fb_b), .finish(finish),
    .a_q(a_q), .b_q(b_q), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .busy(busy), .iter_cnt(iter_cnt)
  );

  gcd_operand_stage #(.WIDTH(W), .CNT_W(CW), .MAX_ITER(3), .AUTO_FINISH(1'b0)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(tbus),
    .sel_a(t_sel_a), .sel_b(t_sel_b), .fb_a(t_fb_a), .fb_b(t_fb_b), .finish(t_finish),
    .a_q(t_a_q), .b_q(t_b_q), .a_eq_b(t_a_eq_b), .a_lt_b(t_a_lt_b), .busy(t_busy), .iter_cnt(t_iter_cnt)
  );

  int vec_count   = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] gcd;
    int           iters;
  } vec_t;

  vec_t vecs [9];

  task automatic wait_in_ready();
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", bus.in_ready, 1);
  endtask

  // Acts as the subtractive-GCD controller: feed back |a-b| into the larger operand each RUN cycle.
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int waits, output bit saw_busy);
    wait_in_ready();
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("load_a", a_q, a);
    check("load_b", b_q, b);
    check("flag_lt", a_lt_b, (a < b));
    check("flag_eq", a_eq_b, (a == b));
    waits    = 0;
    saw_busy = 1'b0;
    while (!bus.out_valid && waits < 400) begin
      if (busy) saw_busy = 1'b1;
      sel_a = SEL_HOLD;
      sel_b = SEL_HOLD;
      if (busy && a_q > b_q) begin
        sel_a = SEL_FB;
        fb_a  = a_q - b_q;
      end else if (busy && b_q > a_q) begin
        sel_b = SEL_FB;
        fb_b  = b_q - a_q;
      end
      @(negedge clk);
      waits++;
    end
    sel_a = SEL_HOLD;
    sel_b = SEL_HOLD;
    check("out_valid", bus.out_valid, 1);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_done", bus.in_ready, 1);
    check("out_valid_after_done", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  waits;
    bit  saw_busy;
    bit  zero;

    vecs[0] = '{a: 5'd12, b: 5'd18, gcd: 5'd6,  iters: 2};
    vecs[1] = '{a: 5'd0,  b: 5'd7,  gcd: 5'd7,  iters: 0};
    vecs[2] = '{a: 5'd0,  b: 5'd0,  gcd: 5'd0,  iters: 0};
    vecs[3] = '{a: 5'd21, b: 5'd14, gcd: 5'd7,  iters: 2};
    vecs[4] = '{a: 5'd17, b: 5'd5,  gcd: 5'd1,  iters: 6};
    vecs[5] = '{a: 5'd31, b: 5'd31, gcd: 5'd31, iters: 0};
    vecs[6] = '{a: 5'd8,  b: 5'd0,  gcd: 5'd8,  iters: 0};
    vecs[7] = '{a: 5'd30, b: 5'd12, gcd: 5'd6,  iters: 3};
    vecs[8] = '{a: 5'd1,  b: 5'd31, gcd: 5'd1,  iters: 30};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    tbus.in_valid = 1'b0; tbus.in_a = '0; tbus.in_b = '0; tbus.out_ready = 1'b0;
    sel_a = SEL_HOLD; sel_b = SEL_HOLD; fb_a = '0; fb_b = '0; finish = 1'b0;
    t_sel_a = SEL_HOLD; t_sel_b = SEL_HOLD; t_fb_a = '0; t_fb_b = '0; t_finish = 1'b0;

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_a_q", a_q, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    check("rst_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      zero = (vecs[i].a == '0) || (vecs[i].b == '0);
      run_pair(vecs[i].a, vecs[i].b, waits, saw_busy);
      check("out_data", bus.out_data, vecs[i].gcd);
      check("iter_cnt", iter_cnt, vecs[i].iters);
      check("timeout", bus.timeout, 0);
      check("latency", waits, zero ? 0 : vecs[i].iters + 1);
      check("busy_seen", saw_busy, !zero);
      $display("vec %0d: gcd(%0d,%0d) -> %0d, iters %0d, waits %0d",
               i, vecs[i].a, vecs[i].b, bus.out_data, iter_cnt, waits);
      release_result();
    end

    // Swap both operands, then finish while both selects request feedback.
    wait_in_ready();
    bus.in_valid = 1'b1; bus.in_a = 5'd9; bus.in_b = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("swap_lt_before", a_lt_b, 1);
    sel_a = SEL_SWAP; sel_b = SEL_SWAP;
    @(negedge clk);
    check("swap_a", a_q, 20);
    check("swap_b", b_q, 9);
    check("swap_lt_after", a_lt_b, 0);
    check("swap_iter", iter_cnt, 1);
    finish = 1'b1; sel_a = SEL_FB; sel_b = SEL_FB; fb_a = 5'd3; fb_b = 5'd4;
    @(negedge clk);
    finish = 1'b0; sel_a = SEL_HOLD; sel_b = SEL_HOLD;
    check("fin_out_valid", bus.out_valid, 1);
    check("fin_out_data", bus.out_data, 20);
    check("fin_hold_a", a_q, 20);
    check("fin_hold_b", b_q, 9);
    check("fin_iter", iter_cnt, 1);
    $display("swap/finish: out_data %0d a_q %0d b_q %0d", bus.out_data, a_q, b_q);

    // Backpressure: result stays put and new pairs are refused while DONE.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = W'(i + 1); bus.in_b = 5'd3;
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 20);
      check("bp_a_q", a_q, 20);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    release_result();
    check("bp_no_accept", a_q, 20);
    $display("backpressure: released after 5 stalled cycles");

    // Asynchronous reset mid-RUN, asserted between clock edges.
    wait_in_ready();
    bus.in_valid = 1'b1; bus.in_a = 5'd5; bus.in_b = 5'd10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_a_q", a_q, 0);
    check("arst_b_q", b_q, 0);
    check("arst_iter", iter_cnt, 0);
    check("arst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    $display("async reset mid-RUN: state cleared");

    // Timeout instance: MAX_ITER=3, no auto-finish, selects held.
    tbus.in_valid = 1'b1; tbus.in_a = 5'd5; tbus.in_b = 5'd10;
    @(negedge clk);
    tbus.in_valid = 1'b0;
    waits = 0;
    while (!tbus.out_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("to_out_valid", tbus.out_valid, 1);
    check("to_run_cycles", waits, 4);
    check("to_timeout", tbus.timeout, 1);
    check("to_out_data", tbus.out_data, 5);
    check("to_iter", t_iter_cnt, 3);
    check("to_busy", t_busy, 0);
    tbus.out_ready = 1'b1;
    @(negedge clk);
    tbus.out_ready = 1'b0;
    check("to_in_ready", tbus.in_ready, 1);
    $display("timeout: out_data %0d after %0d RUN cycles", tbus.out_data, waits);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
